// File: rtl/ir_decode_seq_if.sv
// ir_decode_seq_if: instruction-word valid/ready handshake into the sequential decoder.
interface ir_decode_seq_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_in;
  modport master (output instr_valid, output instr_in, input instr_ready);
  modport slave (input instr_valid, input instr_in, output instr_ready);
endinterface

// File: rtl/ir_decode_seq.sv
// ir_decode_seq: multicycle MIPS decoder, registered fields plus EXEC1/EXEC2 phase FSM driving write_en.
// Define IR_DECODE_ILLEGAL_TRAP_EN to make an illegal word set a sticky flag and halt until reset.
module ir_decode_seq #(
  parameter int IMM_WIDTH        = 32,
  parameter int CODE_WIDTH       = 7,
  parameter bit ZERO_EXT_LOGICAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  ir_decode_seq_if.slave        bus,
  input  logic                  stall,
  output logic [4:0]            register_one,
  output logic [4:0]            register_two,
  output logic [4:0]            destination_reg,
  output logic [4:0]            shift,
  output logic [IMM_WIDTH-1:0]  immediate,
  output logic [25:0]           memory,
  output logic [CODE_WIDTH-1:0] instruction_code,
  output logic [1:0]            phase,
  output logic                  write_en,
  output logic                  illegal
);
`ifdef IR_DECODE_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC1 = 2'd1, EXEC2 = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC1 = 2'd1, EXEC2 = 2'd2} state_t;
`endif
  state_t state, nxt, acc_st;
  logic [5:0] op, fn, c;
  logic [4:0] rt, rd, d_dest;
  logic r_type, j_type, link, d_e1, d_e2, d_two, zx, acc, e1, e2, two;
  logic [IMM_WIDTH-1:0] d_imm;
  assign op = bus.instr_in[31:26];
  assign rt = bus.instr_in[20:16];
  assign rd = bus.instr_in[15:11];
  assign fn = bus.instr_in[5:0];
  assign r_type = op == 6'h00;
  assign j_type = op == 6'h02 || op == 6'h03;
  always_comb begin
    c = 6'd0;
    if (r_type)
      case (fn)
        6'h20: c = 6'd1;   6'h21: c = 6'd4;   6'h24: c = 6'd5;   6'h1A: c = 6'd7;
        6'h1B: c = 6'd8;   6'h10: c = 6'd9;   6'h12: c = 6'd10;  6'h11: c = 6'd11;
        6'h13: c = 6'd12;  6'h18: c = 6'd13;  6'h19: c = 6'd14;  6'h25: c = 6'd15;
        6'h00: c = 6'd17;  6'h04: c = 6'd18;  6'h2A: c = 6'd19;  6'h2B: c = 6'd22;
        6'h03: c = 6'd23;  6'h07: c = 6'd24;  6'h02: c = 6'd25;  6'h06: c = 6'd26;
        6'h23: c = 6'd27;  6'h26: c = 6'd28;  6'h09: c = 6'd40;  6'h08: c = 6'd41;
        default: c = 6'd0;
      endcase
    else if (op == 6'h01)
      case (rt)
        5'h00: c = 6'd35;  5'h01: c = 6'd31;  5'h10: c = 6'd36;  5'h11: c = 6'd32;
        default: c = 6'd0;
      endcase
    else
      case (op)
        6'h08: c = 6'd2;   6'h09: c = 6'd3;   6'h0C: c = 6'd6;   6'h0D: c = 6'd16;
        6'h0A: c = 6'd20;  6'h0B: c = 6'd21;  6'h0E: c = 6'd29;  6'h04: c = 6'd30;
        6'h07: c = 6'd33;  6'h06: c = 6'd34;  6'h05: c = 6'd37;  6'h02: c = 6'd38;
        6'h03: c = 6'd39;  6'h20: c = 6'd42;  6'h24: c = 6'd43;  6'h21: c = 6'd44;
        6'h25: c = 6'd45;  6'h0F: c = 6'd46;  6'h23: c = 6'd47;  6'h22: c = 6'd48;
        6'h26: c = 6'd49;  6'h28: c = 6'd50;  6'h29: c = 6'd51;  6'h2B: c = 6'd52;
        default: c = 6'd0;
      endcase
  end
  // Codes are ordered so branches, jumps, loads and stores (all two-phase) occupy 30 and up.
  assign link   = c == 6'd32 || c == 6'd36 || c == 6'd39;
  assign d_two  = c >= 6'd30;
  assign d_e1   = c inside {[6'd1:6'd6], 6'd9, 6'd10, [6'd15:6'd29]};
  assign d_e2   = link || c inside {6'd40, [6'd42:6'd49]};
  assign d_dest = c == 6'd0 ? 5'd0 : link ? 5'd31 : r_type ? rd : j_type ? 5'd0 : rt;
  assign zx     = ZERO_EXT_LOGICAL && c inside {6'd6, 6'd16, 6'd29};
  assign d_imm  = (r_type || j_type) ? '0 : zx ? IMM_WIDTH'(bus.instr_in[15:0]) : IMM_WIDTH'($signed(bus.instr_in[15:0]));
  assign bus.instr_ready = state == IDLE || (!stall && (state == EXEC2 || (state == EXEC1 && !two)));
  assign acc = bus.instr_valid && bus.instr_ready;
  assign phase = state;
`ifdef IR_DECODE_ILLEGAL_TRAP_EN
  assign acc_st = c == 6'd0 ? HALT : EXEC1;
  always_ff @(posedge clk) illegal <= reset ? 1'b0 : illegal || (acc && c == 6'd0);
`else
  assign acc_st = EXEC1;
  assign illegal = 1'b0;
`endif
  // Link ops always target r31, so a zero destination alone suppresses the write.
  always_comb begin
    nxt = state;
    write_en = !reset && !stall && destination_reg != 5'd0 && ((state == EXEC1 && e1) || (state == EXEC2 && e2));
    if (acc) nxt = acc_st;
    else if (!stall && state == EXEC1) nxt = two ? EXEC2 : IDLE;
    else if (!stall && state == EXEC2) nxt = IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      register_one     <= '0;
      register_two     <= '0;
      destination_reg  <= '0;
      shift            <= '0;
      immediate        <= '0;
      memory           <= '0;
      instruction_code <= '0;
      e1               <= 1'b0;
      e2               <= 1'b0;
      two              <= 1'b0;
    end else if (acc) begin
      register_one     <= bus.instr_in[25:21];
      register_two     <= j_type ? 5'd0 : rt;
      destination_reg  <= d_dest;
      shift            <= r_type ? bus.instr_in[10:6] : 5'd0;
      immediate        <= d_imm;
      memory           <= j_type ? bus.instr_in[25:0] : 26'd0;
      instruction_code <= CODE_WIDTH'(c);
      e1               <= d_e1;
      e2               <= d_e2;
      two              <= d_two;
    end
  end
endmodule

// File: tb/tb_ir_decode_seq.sv
// tb_ir_decode_seq: directed and random stimulus checked each cycle against a table-driven decode model.
module tb_ir_decode_seq;
`ifdef IR_DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, stall;
  logic [4:0] register_one, register_two, destination_reg, shift;
  logic [31:0] immediate, immediate2;
  logic [25:0] memory, mem_2;
  logic [6:0] instruction_code, code_2;
  logic [1:0] phase, ph_2;
  logic write_en, illegal, we_2, ill_2;
  logic [4:0] r1_2, r2_2, dst_2, sh_2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ir_decode_seq_if bus();
  ir_decode_seq_if bus2();
  assign bus2.instr_valid = bus.instr_valid;
  assign bus2.instr_in = bus.instr_in;
  ir_decode_seq #(.IMM_WIDTH(32), .CODE_WIDTH(7), .ZERO_EXT_LOGICAL(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall(stall), .register_one(register_one),
    .register_two(register_two), .destination_reg(destination_reg), .shift(shift), .immediate(immediate),
    .memory(memory), .instruction_code(instruction_code), .phase(phase), .write_en(write_en), .illegal(illegal));
  ir_decode_seq #(.IMM_WIDTH(32), .CODE_WIDTH(7), .ZERO_EXT_LOGICAL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .stall(stall), .register_one(r1_2),
    .register_two(r2_2), .destination_reg(dst_2), .shift(sh_2), .immediate(immediate2),
    .memory(mem_2), .instruction_code(code_2), .phase(ph_2), .write_en(we_2), .illegal(ill_2));
  // Code n is table entry n-1. Kind 0: R-type funct, 1: REGIMM rt, 2: primary opcode.
  int kd[52] = '{0,2,2,0,0,2,0,0,0,0, 0,0,0,0,0,2,0,0,0,2, 2,0,0,0,0,0,0,0,2,2,
                 1,1,2,2,1,1,2,2,2,0, 0,2,2,2,2,2,2,2,2,2, 2,2};
  int ky[52] = '{'h20,'h08,'h09,'h21,'h24,'h0C,'h1A,'h1B,'h10,'h12, 'h11,'h13,'h18,'h19,'h25,'h0D,'h00,'h04,'h2A,'h0A,
                 'h0B,'h2B,'h03,'h07,'h02,'h06,'h23,'h26,'h0E,'h04, 'h01,'h11,'h07,'h06,'h00,'h10,'h05,'h02,'h03,'h09,
                 'h08,'h20,'h24,'h21,'h25,'h0F,'h23,'h22,'h26,'h28, 'h29,'h2B};
  int e1_ops[$]   = '{1,4,5,15,28,17,18,23,24,25,26,19,22,27,9,10,2,3,6,16,29,20,21};
  int e2_ops[$]   = '{39,40,32,36,42,43,44,45,46,47,48,49};
  int two_ops[$]  = '{30,31,32,33,34,35,36,37,38,39,40,41,42,43,44,45,46,47,48,49,50,51,52};
  int link_ops[$] = '{39,32,36};
  int zext_ops[$] = '{6,16,29};
  typedef struct {int code; int r1; int r2; int dest; int sh; int mem; longint imm; longint immn;} f_t;
  f_t m_f;
  bit m_busy, m_halt, m_ld, m_ill;
  int m_ph, m_nph;

  function automatic bit has(input int q[$], input int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_code(input logic [31:0] w);
    for (int i = 0; i < 52; i++)
      if ((kd[i] == 0 && w[31:26] == 0 && w[5:0] == ky[i]) || (kd[i] == 1 && w[31:26] == 1 && w[20:16] == ky[i]) ||
          (kd[i] == 2 && w[31:26] == ky[i])) return i + 1;
    return 0;
  endfunction

  function automatic f_t ref_dec(input logic [31:0] w);
    f_t f;
    int v;
    v = int'(w[15:0]);
    f = '{default: 0};
    f.code = ref_code(w);
    f.r1 = int'(w[25:21]);
    if (w[31:26] == 0) begin
      f.r2 = int'(w[20:16]); f.dest = int'(w[15:11]); f.sh = int'(w[10:6]);
    end else if (w[31:26] == 2 || w[31:26] == 3) begin
      f.mem = int'(w[25:0]);
    end else begin
      f.r2 = int'(w[20:16]); f.dest = int'(w[20:16]);
      f.immn = v >= 32768 ? v - 65536 : v;
      f.imm = has(zext_ops, f.code) ? v : f.immn;
    end
    if (has(link_ops, f.code)) f.dest = 31;
    if (f.code == 0) f.dest = 0;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check every output against the model, then advance the model.
  task automatic cyc(input bit v, input logic [31:0] w, input bit s, input bit r);
    f_t f;
    bit rdy, we;
    int ph;
    bus.instr_valid = v; bus.instr_in = w; stall = s; reset = r;
    #2;
    f = m_ld ? m_f : '{default: 0};
    ph = m_halt ? 3 : m_busy ? m_ph : 0;
    rdy = !m_halt && (!m_busy || (m_ph == m_nph && !s));
    we = m_busy && !s && !r && (f.dest != 0 || has(link_ops, f.code)) &&
         ((m_ph == 1 && has(e1_ops, f.code)) || (m_ph == 2 && has(e2_ops, f.code)));
    chk("phase", 64'(phase), 64'(ph));
    chk("ready", 64'(bus.instr_ready), 64'(rdy));
    chk("write_en", 64'(write_en), 64'(we));
    chk("illegal", 64'(illegal), 64'(m_ill));
    chk("code", 64'(instruction_code), 64'(f.code));
    chk("register_one", 64'(register_one), 64'(f.r1));
    chk("register_two", 64'(register_two), 64'(f.r2));
    chk("destination_reg", 64'(destination_reg), 64'(f.dest));
    chk("shift", 64'(shift), 64'(f.sh));
    chk("memory", 64'(memory), 64'(f.mem));
    chk("immediate", 64'(immediate), 64'(f.imm) & 64'hFFFF_FFFF);
    chk("immediate_sext", 64'(immediate2), 64'(f.immn) & 64'hFFFF_FFFF);
    chk("dut2_rest", {7'd0, r1_2, r2_2, dst_2, sh_2, mem_2, code_2, ph_2, we_2, ill_2, bus2.instr_ready},
        {7'd0, 5'(f.r1), 5'(f.r2), 5'(f.dest), 5'(f.sh), 26'(f.mem), 7'(f.code), 2'(ph), we, m_ill, rdy});
    if (r) begin
      m_busy = 0; m_halt = 0; m_ld = 0; m_ill = 0;
    end else if (v && rdy) begin
      m_f = ref_dec(w); m_ld = 1;
      if (TRAP && m_f.code == 0) begin
        m_halt = 1; m_ill = 1; m_busy = 0;
      end else begin
        m_busy = 1; m_ph = 1; m_nph = has(two_ops, m_f.code) ? 2 : 1;
      end
    end else if (m_busy && !s) begin
      if (m_ph < m_nph) m_ph++;
      else m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr_in = '0; stall = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 32'h0, 0, 1);
    // ADDIU $2,$1,-1: one-phase write
    cyc(1, 32'h2422FFFF, 0, 0);
    chk("addiu_code", 64'(instruction_code), 64'd3);
    chk("addiu_rs", 64'(register_one), 64'd1);
    chk("addiu_dest", 64'(destination_reg), 64'd2);
    chk("addiu_imm", 64'(immediate), 64'hFFFF_FFFF);
    chk("addiu_we", 64'(write_en), 64'd1);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0);
    // ORI: zero- vs sign-extended immediate
    cyc(1, 32'h34038000, 0, 0);
    chk("ori_code", 64'(instruction_code), 64'd16);
    chk("ori_imm", 64'(immediate), 64'h8000);
    chk("ori_imm_sext", 64'(immediate2), 64'hFFFF_8000);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0);
    // JAL, then ADDIU offered during EXEC2
    cyc(1, 32'h0C000010, 0, 0);
    chk("jal_code", 64'(instruction_code), 64'd39);
    chk("jal_memory", 64'(memory), 64'h10);
    chk("jal_dest", 64'(destination_reg), 64'd31);
    chk("jal_we_exec1", 64'(write_en), 64'd0);
    cyc(0, 32'h0, 0, 0);
    chk("jal_we_exec2", 64'(write_en), 64'd1);
    cyc(1, 32'h2422FFFF, 0, 0);
    chk("b2b_phase", 64'(phase), 64'd1);
    chk("b2b_code", 64'(instruction_code), 64'd3);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0);
    // LW stalled three cycles in EXEC2
    cyc(1, 32'h8CA40008, 0, 0);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(1, 32'h2422FFFF, 1, 0);
    chk("lw_stall_phase", 64'(phase), 64'd2);
    chk("lw_stall_we", 64'(write_en), 64'd0);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0);
    // BLTZAL abandoned by reset in EXEC2
    cyc(1, 32'h04D0FFFE, 0, 0);
    cyc(0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 1);
    chk("bltzal_rst_phase", 64'(phase), 64'd0);
    chk("bltzal_rst_dest", 64'(destination_reg), 64'd0);
    cyc(0, 32'h0, 0, 0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] w;
      int i;
      w = $urandom;
      if ($urandom_range(0, 15) != 0) begin
        i = $urandom_range(0, 51);
        if (kd[i] == 0) begin w[31:26] = 6'd0; w[5:0] = 6'(ky[i]); end
        else if (kd[i] == 1) begin w[31:26] = 6'd1; w[20:16] = 5'(ky[i]); end
        else w[31:26] = 6'(ky[i]);
      end
      cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) == 0,
          m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0));
    end
    cyc(0, 32'h0, 0, 1);
    cyc(0, 32'h0, 0, 0);
    // Illegal word
    cyc(1, 32'hFC000000, 0, 0);
    chk("ill_code", 64'(instruction_code), 64'd0);
    chk("ill_phase", 64'(phase), TRAP ? 64'd3 : 64'd1);
    chk("ill_flag", 64'(illegal), 64'(TRAP));
    cyc(1, 32'h2422FFFF, 0, 0);
    cyc(1, 32'h2422FFFF, 0, 0);
    chk("ill_ready", 64'(bus.instr_ready), TRAP ? 64'd0 : 64'd1);
    cyc(0, 32'h0, 0, 1);
    chk("ill_cleared", 64'(illegal), 64'd0);
    cyc(0, 32'h0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ir_decode_seq.md
Name: ir_decode_seq

Overview:
Sequential instruction decoder for the multicycle MIPS core. It accepts a 32-bit instruction word over a valid/ready handshake and latches it into an internal instruction register. It registers every decoded field, then steps an internal EXEC1/EXEC2 phase FSM that drives the per-phase register-file write enable. It sits between the instruction-fetch path and the register file / ALU / control sequencer.

Parameters:
IMM_WIDTH, 32, width of the extended immediate output; legal range 16..64.
CODE_WIDTH, 7, width of instruction_code; minimum 6.
ZERO_EXT_LOGICAL, 1, 1 = ANDI/ORI/XORI immediates zero-extended; 0 = sign-extended like all others.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
instr_valid  in  1  instr_in holds a fetched word.
instr_ready  out  1  decoder can accept a word this cycle.
instr_in  in  32  raw instruction word.
stall  in  1  hold current phase (memory wait).
register_one  out  5  rs.
register_two  out  5  rt (R- and I-type); 0 for J-type.
destination_reg  out  5  write-back register.
shift  out  5  shamt; R-type only, else 0.
immediate  out  IMM_WIDTH  extended imm[15:0]; 0 for R/J.
memory  out  26  J-type target field; else 0.
instruction_code  out  CODE_WIDTH  enumerated op, 0 = invalid.
phase  out  2  0 IDLE, 1 EXEC1, 2 EXEC2.
write_en  out  1  register-file write enable.
illegal  out  1  see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset, state = IDLE and every output is 0 except instr_ready, which is 1.
- Handshake: accept = instr_valid && instr_ready.
  - instr_ready = (state==IDLE) || (final exec phase && !stall).
  - On accept: latch the word, register all decoded fields, enter EXEC1 on the next edge. Latency is 1 cycle from accept to fields valid.
  - Fields hold stable until the next accept.
- Code map:
  - ADD=1 ... XORI=29, BEQ=30 ... JR=41, LB=42 ... SW=52, in the order ADD, ADDI, ADDIU, ADDU, AND, ANDI, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MULT, MULTU, OR, ORI, SLL, SLLV, SLT, SLTI, SLTIU, SLTU, SRA, SRAV, SRL, SRLV, SUBU, XOR, XORI, BEQ, BGEZ, BGEZAL, BGTZ, BLEZ, BLTZ, BLTZAL, BNE, J, JAL, JALR, JR, LB, LBU, LH, LHU, LUI, LW, LWL, LWR, SB, SH, SW.
  - Any unlisted opcode, funct or REGIMM rt value decodes to code 0.
- Field types:
  - R-type is opcode 0. J-type is opcode 2/3. Everything else is I-type.
  - register_two = rt for both R- and I-type.
- destination_reg:
  - R-type: rd.
  - I-type: rt.
  - JAL, BGEZAL, BLTZAL: 31.
  - Code 0: 0.
- immediate:
  - Sign-extend imm[15:0] to IMM_WIDTH.
  - Zero-extend instead for ANDI/ORI/XORI when ZERO_EXT_LOGICAL=1.
- FSM transitions (all suppressed when stall=1 in EXEC1/EXEC2; stall ignored in IDLE):
  - IDLE -> EXEC1 on accept.
  - EXEC1 -> EXEC2 if the op is two-phase. Two-phase ops: branches, J, JAL, JALR, JR, all loads, LUI, stores.
  - EXEC1 -> IDLE otherwise; or straight to EXEC1 if a new word is accepted in the same cycle.
  - EXEC2 -> IDLE, or -> EXEC1 on a same-cycle accept.
- write_en (combinational from state and registered code; 0 when stall=1 or in IDLE):
  - EXEC1: ADD, ADDU, AND, OR, XOR, SLL, SLLV, SRA, SRAV, SRL, SRLV, SLT, SLTU, SUBU, MFHI, MFLO, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU.
  - EXEC2: JAL, JALR, BGEZAL, BLTZAL, LB, LBU, LH, LHU, LUI, LW, LWL, LWR.
  - All other op/phase combinations: 0.
  - Never asserted for code 0, or when destination_reg==0 and the op is not a link op.
- Back-to-back: a word accepted in the final phase begins EXEC1 next cycle, with no bubble.
- Reset mid-operation: abandons the current word. The next cycle is IDLE with fields cleared and write_en=0.

Optional Feature:
Macro IR_DECODE_ILLEGAL_TRAP_EN.
- Defined: accepting a word that decodes to code 0 sets illegal=1 (sticky) and the FSM enters a HALT state (phase=3). In HALT, instr_ready=0 and write_en=0 until reset.
- Undefined: code 0 is treated as a one-phase NOP, illegal is tied to 0, and no HALT state exists.

Test Plan:
- 0x2422FFFF (ADDIU $2,$1,-1) -> next cycle: code 3, register_one 1, destination_reg 2, immediate 0xFFFFFFFF. write_en=1 in EXEC1 only, then IDLE.
- 0x34038000 (ORI), ZERO_EXT_LOGICAL=1 -> code 16, immediate 0x00008000, write_en in EXEC1. With ZERO_EXT_LOGICAL=0 -> immediate 0xFFFF8000.
- 0x0C000010 (JAL) then ADDIU offered during EXEC2 -> code 39, memory 0x10, destination_reg 31. write_en=0 in EXEC1 and 1 in EXEC2; ADDIU then enters EXEC1 with no bubble.
- 0x8CA40008 (LW $4,8($5)) with stall=1 for 3 EXEC2 cycles -> phase holds at 2, write_en=0 and instr_ready=0 while stalled. write_en=1 for exactly one cycle after stall drops.
- 0x04D0FFFE (BLTZAL $6) with reset asserted in EXEC2 -> next cycle IDLE, all fields 0, write_en never asserted.
- 0xFC000000 -> code 0. With the macro defined: illegal=1, phase=3, instr_ready=0 until reset. Without it: one-phase NOP, illegal=0.
